// File: rtl/store_merge_unit.sv
// Store path into a word-wide RAM without byte enables: word stores write directly,
// half/byte stores read-modify-write. Define STORE_ALIGN_CHK_EN to flag misaligned stores on st_err.
module store_merge_unit #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              w,
  input  logic              h,
  input  logic              b,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CAP, S_WR, S_ERR} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t            state;
  state_t            next_state;
  size_t             req_size;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       rmw_word;
  logic [31:0]       merged;
  logic [1:0]        wait_cnt;
  logic              accept;
  logic              misaligned;

  assign accept   = st_req & ~st_busy;
  assign mem_addr = addr_q[ADDR_W-1:2];

  always_comb begin
    case ({w, h, b})
      3'b010:  req_size = SZ_HALF;
      3'b001:  req_size = SZ_BYTE;
      default: req_size = SZ_WORD;
    endcase
  end

`ifdef STORE_ALIGN_CHK_EN
  assign misaligned = ((req_size == SZ_HALF) && st_addr[0]) ||
                      ((req_size == SZ_WORD) && (st_addr[1:0] != 2'b00));
  assign st_err     = (state == S_ERR);
`else
  assign misaligned = 1'b0;
  assign st_err     = 1'b0;
`endif

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    st_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (misaligned)               next_state = S_ERR;
          else if (req_size == SZ_WORD) next_state = S_WR;
          else                          next_state = S_RD;
        end
      end
      S_RD: begin
        mem_rd     = 1'b1;
        next_state = (RD_LAT == 1) ? S_CAP : S_WAIT;
      end
      // wait_cnt counts down the remaining read latency; CAP lines up with rdata valid
      S_WAIT: begin
        if (wait_cnt == 2'd1) next_state = S_CAP;
      end
      S_CAP: next_state = S_WR;
      S_WR: begin
        mem_wr     = 1'b1;
        st_done    = 1'b1;
        next_state = S_IDLE;
      end
      S_ERR: begin
        st_done    = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Little-endian lane replacement on top of the captured RAM word
  always_comb begin
    merged = rmw_word;
    case (size_q)
      SZ_HALF: begin
        if (addr_q[1]) merged[31:16] = data_q[15:0];
        else           merged[15:0]  = data_q[15:0];
      end
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = data_q[7:0];
          2'd1:    merged[15:8]  = data_q[7:0];
          2'd2:    merged[23:16] = data_q[7:0];
          default: merged[31:24] = data_q[7:0];
        endcase
      end
      default: merged = data_q;
    endcase
  end

  assign mem_wdata = (state == S_WR) ? merged : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      st_busy  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= SZ_WORD;
      rmw_word <= '0;
      wait_cnt <= '0;
    end else begin
      state   <= next_state;
      st_busy <= (next_state != S_IDLE);
      if (accept) begin
        addr_q <= st_addr;
        data_q <= st_data;
        size_q <= req_size;
      end
      if (state == S_RD)        wait_cnt <= WAIT_INIT;
      else if (state == S_WAIT) wait_cnt <= wait_cnt - 2'd1;
      if (state == S_CAP) rmw_word <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: one instance with RD_LAT=1 and one with RD_LAT=3 share the
// stimulus; each has its own RAM model and write scoreboard. Honors STORE_ALIGN_CHK_EN.
module tb_store_merge_unit;

  localparam int ADDR_W = 32;
`ifdef STORE_ALIGN_CHK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              w, h, b;

  logic              st_busy1, st_done1, st_err1, mem_rd1, mem_wr1;
  logic [ADDR_W-3:0] mem_addr1;
  logic [31:0]       mem_wdata1, mem_rdata1;
  logic              st_busy3, st_done3, st_err3, mem_rd3, mem_wr3;
  logic [ADDR_W-3:0] mem_addr3;
  logic [31:0]       mem_wdata3, mem_rdata3;

  int total = 0;
  int bad   = 0;
  int rd_cnt1 = 0;
  int rd_cnt3 = 0;
  logic [31:0] q_addr1[$];
  logic [31:0] q_data1[$];
  logic [31:0] q_addr3[$];
  logic [31:0] q_data3[$];
  logic [31:0] ea1, ed1, ea3, ed3;

  always #5 clk = ~clk;

  store_merge_unit #(.ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .w(w), .h(h), .b(b), .st_busy(st_busy1), .st_done(st_done1), .st_err(st_err1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  store_merge_unit #(.ADDR_W(ADDR_W), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .w(w), .h(h), .b(b), .st_busy(st_busy3), .st_done(st_done3), .st_err(st_err3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_wr(mem_wr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // RAM models: data appears RD_LAT cycles after the read strobe, junk otherwise
  logic [31:0] ram1 [0:63];
  logic [31:0] ram3 [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  logic        rd1_v;
  logic [31:0] rd1_d;
  logic [2:0]  rd3_v;
  logic [31:0] rd3_d [0:2];

  always @(posedge clk) begin
    if (pl_en) begin
      ram1[pl_idx] <= pl_data;
      ram3[pl_idx] <= pl_data;
    end
    if (mem_wr1) ram1[mem_addr1[5:0]] <= mem_wdata1;
    if (mem_wr3) ram3[mem_addr3[5:0]] <= mem_wdata3;
    rd1_d    <= ram1[mem_addr1[5:0]];
    rd3_d[0] <= ram3[mem_addr3[5:0]];
    rd3_d[1] <= rd3_d[0];
    rd3_d[2] <= rd3_d[1];
    if (rst) begin
      rd1_v <= 1'b0;
      rd3_v <= 3'b000;
    end else begin
      rd1_v <= mem_rd1;
      rd3_v <= {rd3_v[1:0], mem_rd3};
    end
  end

  assign mem_rdata1 = rd1_v    ? rd1_d    : 32'hBAD0_BAD0;
  assign mem_rdata3 = rd3_v[2] ? rd3_d[2] : 32'hBAD0_BAD0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (mem_rd1) rd_cnt1++;
    if (mem_rd3) rd_cnt3++;
    if (mem_wr1) begin
      check_output("wr1_expected", 32'(q_addr1.size() != 0), 32'd1);
      if (q_addr1.size() != 0) begin
        ea1 = q_addr1.pop_front();
        ed1 = q_data1.pop_front();
        check_output("wr1_addr", {2'b00, mem_addr1}, ea1);
        check_output("wr1_data", mem_wdata1, ed1);
      end
    end
    if (mem_wr3) begin
      check_output("wr3_expected", 32'(q_addr3.size() != 0), 32'd1);
      if (q_addr3.size() != 0) begin
        ea3 = q_addr3.pop_front();
        ed3 = q_data3.pop_front();
        check_output("wr3_addr", {2'b00, mem_addr3}, ea3);
        check_output("wr3_data", mem_wdata3, ed3);
      end
    end
  end

  task automatic check_reset(input string name);
    check_output({name, ".ctl1"}, {27'd0, st_busy1, st_done1, st_err1, mem_rd1, mem_wr1}, 32'd0);
    check_output({name, ".addr1"}, {2'b00, mem_addr1}, 32'd0);
    check_output({name, ".wdata1"}, mem_wdata1, 32'd0);
    check_output({name, ".ctl3"}, {27'd0, st_busy3, st_done3, st_err3, mem_rd3, mem_wr3}, 32'd0);
    check_output({name, ".addr3"}, {2'b00, mem_addr3}, 32'd0);
    check_output({name, ".wdata3"}, mem_wdata3, 32'd0);
  endtask

  // Called at a negedge; returns at a negedge one cycle later
  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Called at a negedge (cycle 0); runs 10 cycles and checks timing, strobes and scoreboard
  task automatic apply_stimulus(input string name, input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] whb, input logic [31:0] exp_wdata,
                                input logic exp_err, input logic hold);
    logic is_word;
    int   lat1, lat3, exp_rd;
    int   done1_at, done3_at, done1_n, done3_n, err1_n, err3_n;
    int   rd1_base, rd3_base;
    logic busy_ok1, busy_ok3;
    is_word = !((whb == 3'b010) || (whb == 3'b001));
    lat1    = (exp_err || is_word) ? 1 : 3;
    lat3    = (exp_err || is_word) ? 1 : 5;
    exp_rd  = (exp_err || is_word) ? 0 : 1;
    if (!exp_err) begin
      q_addr1.push_back({2'b00, addr[31:2]});
      q_data1.push_back(exp_wdata);
      q_addr3.push_back({2'b00, addr[31:2]});
      q_data3.push_back(exp_wdata);
    end
    rd1_base = rd_cnt1;
    rd3_base = rd_cnt3;
    done1_at = 0; done3_at = 0; done1_n = 0; done3_n = 0; err1_n = 0; err3_n = 0;
    busy_ok1 = 1'b1;
    busy_ok3 = 1'b1;
    st_req  = 1'b1;
    st_addr = addr;
    st_data = data;
    {w, h, b} = whb;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (st_done1) begin done1_n++; if (done1_at == 0) done1_at = k; end
      if (st_done3) begin done3_n++; if (done3_at == 0) done3_at = k; end
      if (st_err1) err1_n++;
      if (st_err3) err3_n++;
      if (st_busy1 !== (k <= lat1)) busy_ok1 = 1'b0;
      if (st_busy3 !== (k <= lat3)) busy_ok3 = 1'b0;
      if ((hold && (k == lat1 + 1)) || (!hold && (k == 1))) st_req = 1'b0;
    end
    check_output({name, ".lat1"}, done1_at, lat1);
    check_output({name, ".lat3"}, done3_at, lat3);
    check_output({name, ".done_n1"}, done1_n, 1);
    check_output({name, ".done_n3"}, done3_n, 1);
    check_output({name, ".err_n1"}, err1_n, {31'd0, exp_err});
    check_output({name, ".err_n3"}, err3_n, {31'd0, exp_err});
    check_output({name, ".rd_n1"}, rd_cnt1 - rd1_base, exp_rd);
    check_output({name, ".rd_n3"}, rd_cnt3 - rd3_base, exp_rd);
    check_output({name, ".busy1"}, {31'd0, busy_ok1}, 32'd1);
    check_output({name, ".busy3"}, {31'd0, busy_ok3}, 32'd1);
    check_output({name, ".pending1"}, q_addr1.size(), 0);
    check_output({name, ".pending3"}, q_addr3.size(), 0);
  endtask

  initial begin
    rst = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0; w = 1'b0; h = 1'b0; b = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus("sw", 32'h10, 32'hDEADBEEF, 3'b100, 32'hDEADBEEF, 1'b0, 1'b0);
    preload(6'd4, 32'h11223344);
    apply_stimulus("sb_lane3", 32'h13, 32'h000000AB, 3'b001, 32'hAB223344, 1'b0, 1'b0);
    preload(6'd8, 32'hFFFFFFFF);
    apply_stimulus("sh_hi", 32'h22, 32'h1234CAFE, 3'b010, 32'hCAFEFFFF, 1'b0, 1'b0);
    preload(6'd0, 32'h00000000);
    apply_stimulus("sb_lane1", 32'h01, 32'h0000005A, 3'b001, 32'h00005A00, 1'b0, 1'b0);
    preload(6'd3, 32'h89ABCDEF);
    apply_stimulus("sh_lo", 32'h0C, 32'hFFFF1357, 3'b010, 32'h89AB1357, 1'b0, 1'b0);
    preload(6'd10, 32'h01020304);
    apply_stimulus("sb_lane0", 32'h28, 32'h000000C3, 3'b001, 32'h010203C3, 1'b0, 1'b0);
    apply_stimulus("sw_code000", 32'h14, 32'h600DCAFE, 3'b000, 32'h600DCAFE, 1'b0, 1'b0);
    apply_stimulus("sw_code111", 32'h18, 32'h2468ACE0, 3'b111, 32'h2468ACE0, 1'b0, 1'b0);
    preload(6'd1, 32'hAAAAAAAA);
    apply_stimulus("sb_hold", 32'h06, 32'h00000077, 3'b001, 32'hAA77AAAA, 1'b0, 1'b1);
    preload(6'd8, 32'h55667788);
    apply_stimulus("sh_misaligned", 32'h21, 32'h0000BEEF, 3'b010, 32'h5566BEEF, ALIGN_CHK, 1'b0);
    apply_stimulus("sw_misaligned", 32'h23, 32'h13579BDF, 3'b100, 32'h13579BDF, ALIGN_CHK, 1'b0);

    // Abort a byte store with reset mid-flight; it must never write
    preload(6'd4, 32'h11223344);
    st_req = 1'b1; st_addr = 32'h13; st_data = 32'h000000EE; {w, h, b} = 3'b001;
    @(negedge clk);
    st_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0;
    apply_stimulus("sw_after_reset", 32'h30, 32'h0BADF00D, 3'b100, 32'h0BADF00D, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
